// File: rtl/storeq_alloc_ctl.sv
// Store-queue allocation control: circular in-order alloc/free, elder matrix, mempipe grant arbitration.
// Define STQ_AGE_ARB_EN for oldest-first grant; otherwise the grant goes to the lowest requesting index.

module storeq_alloc_ent (
   input  logic clk,
   input  logic reset,
   input  logic alloc_set,
   input  logic flush,
   input  logic keep,
   input  logic e_valid,
   output logic occ,
   output logic freed
);
   logic seen, hold;

   // seen covers the one-cycle gap between the alloc strobe and the entry raising valid
   assign freed = occ & seen & ~e_valid;
   assign hold  = ~freed & (~flush | keep);

   always_ff @(posedge clk) begin
      if (reset) begin
         occ  <= 1'b0;
         seen <= 1'b0;
      end else if (alloc_set) begin
         occ  <= 1'b1;
         seen <= 1'b0;
      end else begin
         occ  <= occ & hold;
         seen <= (seen | e_valid) & hold;
      end
   end
endmodule

module storeq_alloc_ctl #(
   parameter int STQ_NUM_ENTRIES = 8,
   parameter int ID_W            = $clog2(STQ_NUM_ENTRIES)
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic                                       alloc_req_rs0,
   output logic                                       stq_full_rs0,
   output logic [ID_W-1:0]                            alloc_id_rs0,
   output logic [STQ_NUM_ENTRIES-1:0]                 e_alloc_rs0,
   input  logic [STQ_NUM_ENTRIES-1:0]                 e_valid,
   output logic [STQ_NUM_ENTRIES*STQ_NUM_ENTRIES-1:0] e_elders,
   input  logic [STQ_NUM_ENTRIES-1:0]                 e_pipe_req_mm0,
   input  logic                                       pipe_stall_mm0,
   output logic [STQ_NUM_ENTRIES-1:0]                 e_pipe_gnt_mm0,
   output logic                                       pipe_gnt_mm0,
   output logic [ID_W-1:0]                            pipe_gnt_id_mm0,
   input  logic                                       stq_flush_rb1,
   input  logic [STQ_NUM_ENTRIES-1:0]                 stq_flush_keep
);
   localparam int N = STQ_NUM_ENTRIES;

   logic [ID_W-1:0]         head, tail;
   logic [ID_W:0]           count, kept_cnt;
   logic [N-1:0]            occ, freed, head_oh, cand;
   logic [N-1:0][ID_W-1:0]  age;
   logic                    alloc_fire, head_free, found;

   assign stq_full_rs0 = (count == (ID_W+1)'(N));
   assign alloc_id_rs0 = tail;
   assign alloc_fire   = alloc_req_rs0 & ~stq_full_rs0 & ~stq_flush_rb1 & ~reset;
   assign e_alloc_rs0  = alloc_fire ? (N'(1) << tail) : '0;
   assign head_oh      = N'(1) << head;
   assign head_free    = |(freed & head_oh);

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_ent
         storeq_alloc_ent u_ent (
            .clk       (clk),
            .reset     (reset),
            .alloc_set (e_alloc_rs0[gi]),
            .flush     (stq_flush_rb1),
            .keep      (stq_flush_keep[gi]),
            .e_valid   (e_valid[gi]),
            .occ       (occ[gi]),
            .freed     (freed[gi])
         );
         assign age[gi] = ID_W'(gi) - head;
         for (genvar gj = 0; gj < N; gj++) begin : g_eld
            assign e_elders[gi*N+gj] = occ[gi] & occ[gj] & (age[gj] < age[gi]);
         end
      end
   endgenerate

   // survivors of a flush exclude a head entry freeing in the same cycle
   always_comb begin
      kept_cnt = '0;
      for (int i = 0; i < N; i++)
         kept_cnt = kept_cnt + (ID_W+1)'(occ[i] & stq_flush_keep[i] & ~freed[i]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head <= head + ID_W'(head_free);
         if (stq_flush_rb1) begin
            count <= kept_cnt;
            tail  <= head + ID_W'(head_free) + kept_cnt[ID_W-1:0];
         end else begin
            count <= count + (ID_W+1)'(alloc_fire) - (ID_W+1)'(head_free);
            tail  <= tail + ID_W'(alloc_fire);
         end
      end
   end

   assign cand = e_pipe_req_mm0 & occ;

`ifdef STQ_AGE_ARB_EN
   logic [ID_W-1:0] idx;
   always_comb begin
      e_pipe_gnt_mm0  = '0;
      pipe_gnt_id_mm0 = '0;
      found           = 1'b0;
      idx             = '0;
      for (int k = 0; k < N; k++) begin
         idx = head + ID_W'(k);
         if (!found && !pipe_stall_mm0 && cand[idx]) begin
            found           = 1'b1;
            e_pipe_gnt_mm0  = N'(1) << idx;
            pipe_gnt_id_mm0 = idx;
         end
      end
   end
`else
   always_comb begin
      e_pipe_gnt_mm0  = '0;
      pipe_gnt_id_mm0 = '0;
      found           = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!found && !pipe_stall_mm0 && cand[k]) begin
            found           = 1'b1;
            e_pipe_gnt_mm0  = N'(1) << k;
            pipe_gnt_id_mm0 = ID_W'(k);
         end
      end
   end
`endif

   assign pipe_gnt_mm0 = found;

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!reset) assert ((freed & ~head_oh) == '0);
   end
`endif
endmodule

// File: tb/tb_storeq_alloc_ctl.sv
// Bench for storeq_alloc_ctl: vector table, directed corner sequences, random run against a queue model.

module tb_storeq_alloc_ctl;
   localparam int N  = 8;
   localparam int IW = 3;

   logic             clk = 1'b0;
   logic             reset, alloc_req, full, stall, flush, pipe_gnt;
   logic [IW-1:0]    alloc_id, gnt_id;
   logic [N-1:0]     e_alloc, e_valid, req, gnt, keep;
   logic [N*N-1:0]   elders;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   storeq_alloc_ctl #(.STQ_NUM_ENTRIES(N)) dut (
      .clk(clk), .reset(reset), .alloc_req_rs0(alloc_req), .stq_full_rs0(full),
      .alloc_id_rs0(alloc_id), .e_alloc_rs0(e_alloc), .e_valid(e_valid), .e_elders(elders),
      .e_pipe_req_mm0(req), .pipe_stall_mm0(stall), .e_pipe_gnt_mm0(gnt),
      .pipe_gnt_mm0(pipe_gnt), .pipe_gnt_id_mm0(gnt_id),
      .stq_flush_rb1(flush), .stq_flush_keep(keep)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // inputs change on the falling edge; outputs are sampled 1ns later
   task automatic drv(input logic ar, input logic [N-1:0] v, input logic [N-1:0] rq,
                      input logic st, input logic fl, input logic [N-1:0] kp, input logic rs);
      @(negedge clk);
      alloc_req = ar; e_valid = v; req = rq; stall = st; flush = fl; keep = kp; reset = rs;
      #1;
   endtask

   function automatic logic eld(input int i, input int j);
      return elders[i*N+j];
   endfunction

   typedef struct {
      logic          ar;
      logic          exp_full;
      logic [IW-1:0] exp_id;
      logic [N-1:0]  exp_alloc;
   } vec_t;
   vec_t tbl[9];

   // behavioural model: program-order queue of entry ids
   int  q[$];
   int  mhead;
   bit  vis[N];
   bit  seen_m[N];

   initial begin
      logic [N-1:0] ev, rq, kp, exp_gnt, inq;
      logic [63:0]  exp_eld;
      logic         ar, st, fl, retire, fire, mfull;
      int           k, tl, rem, x, exp_gid;

      alloc_req = 0; e_valid = 0; req = 0; stall = 0; flush = 0; keep = 0; reset = 1;
      drv(0, 0, 0, 0, 0, 0, 1);
      drv(1, 0, 0, 0, 0, 0, 1);
      chk("alloc_in_reset", e_alloc, 0);

      // reset state
      drv(0, 0, 8'hFF, 0, 0, 0, 0);
      chk("rst_full", full, 0);
      chk("rst_alloc", e_alloc, 0);
      chk("rst_gnt", gnt, 0);
      chk("rst_pipe_gnt", pipe_gnt, 0);
      chk("rst_gnt_id", gnt_id, 0);
      chk("rst_elders", elders, 0);
      chk("rst_id", alloc_id, 0);

      // alloc stream: 8 back-to-back then one dropped while full
      for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, 1'b0, IW'(i), N'(1) << i};
      tbl[8] = '{1'b1, 1'b1, IW'(0), N'(0)};
      for (int i = 0; i < 9; i++) begin
         drv(tbl[i].ar, 0, 0, 0, 0, 0, 0);
         chk($sformatf("stream%0d_full", i), full, tbl[i].exp_full);
         chk($sformatf("stream%0d_id", i), alloc_id, tbl[i].exp_id);
         chk($sformatf("stream%0d_alloc", i), e_alloc, tbl[i].exp_alloc);
      end

      // alloc+free at count=8, then in-order free with wrap
      drv(0, 8'hFF, 0, 0, 0, 0, 0);
      drv(1, 8'hFE, 0, 0, 0, 0, 0);
      chk("full_free_alloc", e_alloc, 0);
      chk("full_free_full", full, 1);
      drv(1, 8'hFC, 0, 0, 0, 0, 0);
      chk("after_free_full", full, 0);
      chk("reuse_id0", alloc_id, 0);
      chk("reuse_alloc0", e_alloc, 8'h01);
      drv(1, 8'hFC, 0, 0, 0, 0, 0);
      chk("reuse_id1", alloc_id, 1);
      chk("reuse_alloc1", e_alloc, 8'h02);
      drv(0, 8'hFC, 8'h82, 0, 0, 0, 0);
      chk("wrap_full", full, 1);
      chk("elder_1_7", eld(1, 7), 1);
      chk("elder_7_1", eld(7, 1), 0);
      chk("elder_3_2", eld(3, 2), 1);
      chk("elder_2_3", eld(2, 3), 0);
      chk("elder_diag", eld(4, 4), 0);
`ifdef STQ_AGE_ARB_EN
      chk("wrap_gnt", gnt, 8'h80);
      chk("wrap_gnt_id", gnt_id, 7);
`else
      chk("wrap_gnt", gnt, 8'h02);
      chk("wrap_gnt_id", gnt_id, 1);
`endif

      // arbitration with head=6, entries 6,7,0,1 occupied
      drv(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 8; i++) drv(1, 0, 0, 0, 0, 0, 0);
      drv(0, 8'hFF, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) drv(0, 8'hFF & ~((N'(1) << (i + 1)) - 1), 0, 0, 0, 0, 0);
      drv(1, 8'hC0, 0, 0, 0, 0, 0);
      chk("arb_id0", alloc_id, 0);
      drv(1, 8'hC0, 0, 0, 0, 0, 0);
      chk("arb_id1", alloc_id, 1);
      drv(0, 8'hC0, 8'h82, 0, 0, 0, 0);
`ifdef STQ_AGE_ARB_EN
      chk("arb_gnt", gnt, 8'h80);
      chk("arb_gnt_id", gnt_id, 7);
`else
      chk("arb_gnt", gnt, 8'h02);
      chk("arb_gnt_id", gnt_id, 1);
`endif
      chk("arb_pipe_gnt", pipe_gnt, 1);
      drv(0, 8'hC0, 8'h82, 1, 0, 0, 0);
      chk("arb_stall_gnt", gnt, 0);
      chk("arb_stall_pipe", pipe_gnt, 0);

      // reset mid-operation at count=4
      drv(1, 8'hC0, 8'h82, 0, 0, 0, 1);
      chk("midrst_alloc", e_alloc, 0);
      drv(1, 0, 8'h82, 0, 0, 0, 0);
      chk("midrst_full", full, 0);
      chk("midrst_id", alloc_id, 0);
      chk("midrst_alloc_after", e_alloc, 8'h01);
      chk("midrst_gnt", gnt, 0);
      chk("midrst_elders", elders, 0);

      // flush at head=3, count=5, keeping entries 3,4
      drv(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 8; i++) drv(1, 0, 0, 0, 0, 0, 0);
      drv(0, 8'hFF, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) drv(0, 8'hFF & ~((N'(1) << (i + 1)) - 1), 0, 0, 0, 0, 0);
      drv(1, 8'hF8, 0, 0, 1, 8'h18, 0);
      chk("flush_alloc", e_alloc, 0);
      drv(0, 8'h18, 0, 0, 0, 0, 0);
      chk("flush_tail", alloc_id, 5);
      chk("flush_full", full, 0);
      chk("flush_elder_4_3", eld(4, 3), 1);
      chk("flush_elder_5_3", eld(5, 3), 0);
      chk("flush_elder_3_4", eld(3, 4), 0);
      for (int i = 0; i < 6; i++) begin
         drv(1, 8'h18, 0, 0, 0, 0, 0);
         chk($sformatf("flush_refill%0d", i), e_alloc, N'(1) << ((5 + i) % N));
      end
      drv(0, 8'h18, 0, 0, 0, 0, 0);
      chk("flush_refill_full", full, 1);

      // random run against the queue model
      drv(0, 0, 0, 0, 0, 0, 1);
      q.delete();
      mhead = 0;
      for (int i = 0; i < N; i++) begin vis[i] = 0; seen_m[i] = 0; end
      for (int c = 0; c < 3000; c++) begin
         ar     = ($urandom_range(0, 9) < 6);
         retire = (q.size() > 0) && seen_m[q[0]] && ($urandom_range(0, 2) == 0);
         ev = '0;
         for (int i = 0; i < N; i++) ev[i] = vis[i];
         if (retire) ev[q[0]] = 1'b0;
         rq = N'($urandom);
         st = ($urandom_range(0, 3) == 0);
         fl = ($urandom_range(0, 29) == 0);
         k  = fl ? $urandom_range(0, q.size()) : 0;
         kp = '0;
         for (int p = 0; p < k; p++) kp[q[p]] = 1'b1;

         mfull = (q.size() == N);
         tl    = (mhead + q.size()) % N;
         fire  = ar && !mfull && !fl;
         inq   = '0;
         for (int p = 0; p < q.size(); p++) inq[q[p]] = 1'b1;
         exp_eld = '0;
         for (int p = 0; p < q.size(); p++)
            for (int r = 0; r < p; r++) exp_eld[q[p]*N+q[r]] = 1'b1;
         exp_gnt = '0;
         exp_gid = 0;
         if (!st) begin
`ifdef STQ_AGE_ARB_EN
            for (int p = 0; p < q.size(); p++)
               if (exp_gnt == 0 && rq[q[p]]) begin exp_gnt[q[p]] = 1'b1; exp_gid = q[p]; end
`else
            for (int i = 0; i < N; i++)
               if (exp_gnt == 0 && rq[i] && inq[i]) begin exp_gnt[i] = 1'b1; exp_gid = i; end
`endif
         end

         drv(ar, ev, rq, st, fl, kp, 0);
         chk("rnd_full", full, mfull);
         chk("rnd_id", alloc_id, tl);
         chk("rnd_alloc", e_alloc, fire ? (N'(1) << tl) : N'(0));
         chk("rnd_elders", elders, exp_eld);
         chk("rnd_gnt", gnt, exp_gnt);
         chk("rnd_pipe_gnt", pipe_gnt, exp_gnt != 0);
         chk("rnd_gnt_id", gnt_id, exp_gid);

         for (int i = 0; i < N; i++) if (ev[i]) seen_m[i] = 1;
         if (retire) begin
            x = q.pop_front();
            vis[x] = 0; seen_m[x] = 0;
            mhead = (mhead + 1) % N;
         end
         if (fl) begin
            rem = retire ? ((k > 0) ? k - 1 : 0) : k;
            while (q.size() > rem) begin
               x = q.pop_back();
               vis[x] = 0; seen_m[x] = 0;
            end
         end else if (fire) begin
            q.push_back(tl);
            vis[tl] = 1; seen_m[tl] = 0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
